piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage feeding left_shift_register_base. Accepts DEPTH-bit words on a
//  valid/ready handshake and emits them MSB-first, one bit per cycle, with a shift strobe.
//  The strobe drives the downstream register's enable, so DEPTH strobes rebuild the word there.
// PARAMETERS
//  DEPTH  8  word width in bits; legal range >= 2; bit counter width CW = $clog2(DEPTH)
// PORTS
//  clk         in   1      single clock, all state updates on rising edge
//  reset       in   1      synchronous, active-high; sampled on rising edge of clk
//  in_data     in   DEPTH  parallel word to serialize
//  in_valid    in   1      in_data valid
//  in_ready    out  1      block accepts word this cycle (transfer = in_valid & in_ready)
//  hold        in   1      pause shifting; state frozen while high
//  out_bit     out  1      current serial bit (MSB of shift register)
//  out_enable  out  1      shift strobe for downstream: high while a valid bit is on out_bit
//  out_last    out  1      high together with out_enable on bit 0 (final bit) of a word
//  busy        out  1      high when state is SHIFT
// BEHAVIOUR
//  - Reset: state IDLE, shreg=0, count=0, skid empty. Outputs out_bit=0, out_enable=0,
//    out_last=0, busy=0. in_ready is forced 0 while reset is high, 1 on first cycle after.
//  - Reset mid-word: current word and any buffered word are discarded; no further strobes.
//  - FSM states: IDLE, SHIFT.
//  - IDLE: in_ready=1. On transfer: shreg<=in_data, count<=DEPTH-1, -> SHIFT.
//  - SHIFT: out_bit=shreg[DEPTH-1]; out_enable=~hold; out_last=~hold & (count==0).
//    Edge with hold=0: shreg<=shreg<<1, count<=count-1. Edge with hold=1: no change.
//  - Last bit (count==0, hold=0): next word available -> load it, count<=DEPTH-1, stay SHIFT;
//    otherwise -> IDLE.
//  - Latency: word accepted at edge N; its MSB is on out_bit with out_enable=1 during cycle N+1;
//    LSB during cycle N+DEPTH.
//  - hold in IDLE has no effect; hold never blocks acceptance, only shifting.
//  - Word order strictly FIFO; no word dropped or duplicated.
//  - in_data sampled only on transfer; changes while not accepted are ignored.
// CONFIGURATION
//  PISO_SKID_EN defined: one-word skid buffer. in_ready = ~skid_full (also during SHIFT).
//   Transfer in SHIFT stores to skid; if it coincides with last-bit edge and skid is empty,
//   the word bypasses straight into shreg. On last-bit edge a full skid loads shreg and
//   empties. Back-to-back: DEPTH cycles per word, zero strobe gap.
//  PISO_SKID_EN undefined: no skid; in_ready = (state==IDLE). One idle cycle between words;
//   DEPTH+1 cycles per word.
// STRUCTURE
//  - piso_pkg.vh: state encodings (ST_IDLE=1'b0, ST_SHIFT=1'b1), CW localparam helper.
//  - Sub-module piso_skid_buffer (1-entry, valid/ready, DEPTH wide); instantiated only under
//    PISO_SKID_EN. FSM, counter and shift register stay in piso_serializer.
// TESTING
//  - Reset then word 8'b11010110 -> out_bit 1,1,0,1,0,1,1,0 over 8 strobes, out_last on 8th;
//    downstream left_shift_register_base holds 8'b11010110.
//  - hold=1 for 3 cycles mid-word (after bit 3) -> out_enable low 3 cycles, bit sequence
//    unchanged, strobe count still 8.
//  - Words 8'hA5 then 8'h3C presented back-to-back -> skid: 16 contiguous strobes;
//    no skid: 8 strobes, 1-cycle gap, 8 strobes; in_ready low throughout SHIFT.
//  - reset=1 after 4th bit of 8'hFF with 8'h0F buffered -> next cycle out_enable=0, busy=0;
//    following word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
//  - in_valid=1 with in_data toggling while in_ready=0 -> only accepted values appear serially.
//  - DEPTH=2: words 2'b10, 2'b01 -> bits 1,0,0,1; out_last on 2nd and 4th strobes.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: FSM state encoding and counter-width helper for piso_serializer
package piso_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int cw_of(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/piso_skid_buffer.sv
// piso_skid_buffer: one-entry valid/ready holding buffer for the next word
module piso_skid_buffer #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DEPTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic             full_q, full_d;
  logic [DEPTH-1:0] data_q, data_d;
  always_comb begin
    full_d = (in_valid & ~full_q) ? 1'b1 : (out_ready & full_q) ? 1'b0 : full_q;
    data_d = (in_valid & ~full_q) ? in_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign in_ready  = ~full_q;
  assign out_valid = full_q;
  assign out_data  = data_q;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, MSB-first bit stream with shift strobe out.
// PISO_SKID_EN adds a one-word skid buffer so consecutive words stream without a gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             hold,
  output logic             out_bit,
  output logic             out_enable,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = cw_of(DEPTH);
  state_t           state_q, state_d;
  logic [DEPTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             xfer, last_edge, direct, skid_valid;
  logic [DEPTH-1:0] skid_data;
  assign last_edge = (state_q == ST_SHIFT) & ~hold & (count_q == '0);
  assign direct    = (state_q == ST_IDLE) | last_edge;
  assign xfer      = in_valid & in_ready;
`ifdef PISO_SKID_EN
  logic skid_ready;
  // Words arriving when shreg can take them directly bypass the buffer.
  piso_skid_buffer #(.DEPTH(DEPTH)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid & ~direct),
    .in_ready (skid_ready),
    .out_data (skid_data),
    .out_valid(skid_valid),
    .out_ready(last_edge)
  );
  assign in_ready = ~reset & skid_ready;
`else
  assign in_ready   = ~reset & (state_q == ST_IDLE);
  assign skid_valid = 1'b0;
  assign skid_data  = '0;
`endif
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    if (state_q == ST_IDLE) begin
      if (xfer) begin
        shreg_d = in_data;
        count_d = CW'(DEPTH - 1);
        state_d = ST_SHIFT;
      end
    end else if (!hold) begin
      shreg_d = shreg_q << 1;
      count_d = count_q - 1'b1;
      if (count_q == '0) begin
        shreg_d = skid_valid ? skid_data : xfer ? in_data : shreg_q << 1;
        count_d = CW'(DEPTH - 1);
        state_d = (skid_valid | xfer) ? ST_SHIFT : ST_IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end
  assign busy       = (state_q == ST_SHIFT);
  assign out_bit    = shreg_q[DEPTH-1];
  assign out_enable = busy & ~hold;
  assign out_last   = out_enable & (count_q == '0);
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench; accepted words expand into an expected bit queue
module tb_piso_serializer;
  localparam int DEPTH = 8;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, hold = 1'b0, mon_en = 1'b0;
  logic [DEPTH-1:0] in_data = '0, ds = '0;
  logic in_ready, out_bit, out_enable, out_last, busy;
  logic [1:0] d2_data = '0;
  logic d2_valid = 1'b0, d2_ready, d2_bit, d2_en, d2_last, d2_busy;
  logic [1:0] sb[$];
  logic [1:0] d2_q[$];
  int n_cmp = 0, n_bad = 0, strobes = 0, cyc = 0, first_en = 0, last_en = 0;
  bit win_seen = 0;

  always #5 clk = ~clk;

  piso_serializer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .out_bit(out_bit), .out_enable(out_enable), .out_last(out_last), .busy(busy)
  );

  piso_serializer #(.DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_ready),
    .hold(1'b0), .out_bit(d2_bit), .out_enable(d2_en), .out_last(d2_last), .busy(d2_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // downstream left shift register rebuilt from the strobes
  always @(posedge clk) if (out_enable) ds <= {ds[DEPTH-2:0], out_bit};

  always @(negedge clk) begin
    logic [1:0] e;
    bit exp_rdy;
    cyc++;
    if (mon_en) begin
`ifdef PISO_SKID_EN
      exp_rdy = !reset && sb.size() <= DEPTH;
`else
      exp_rdy = !reset && sb.size() == 0;
`endif
      check("in_ready", in_ready, exp_rdy);
      check("busy", busy, sb.size() != 0);
      check("out_enable", out_enable, sb.size() != 0 && !hold);
      if (out_enable) begin
        strobes++;
        if (!win_seen) first_en = cyc;
        win_seen = 1;
        last_en = cyc;
      end
      if (sb.size() != 0 && !hold) begin
        e = sb.pop_front();
        check("out_bit", out_bit, e[0]);
        check("out_last", out_last, e[1]);
      end else check("out_last_idle", out_last, 0);
      if (reset) sb.delete();
      else if (in_valid && in_ready)
        for (int i = DEPTH - 1; i >= 0; i--) sb.push_back({i == 0, in_data[i]});
      if (d2_en) d2_q.push_back({d2_last, d2_bit});
    end
  end

  task automatic send(input logic [DEPTH-1:0] w);
    bit acc;
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 100);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send2(input logic [1:0] w);
    bit acc;
    int t = 0;
    d2_valid = 1'b1;
    d2_data  = w;
    do begin
      @(negedge clk);
      acc = d2_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 100);
    if (!acc) check("send2_timeout", 0, 1);
    d2_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  initial begin
    int s0;
    logic [1:0] exp2[4];
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    send(8'hD6);
    wait_idle();
    check("downstream_d6", ds, 8'hD6);
    s0 = strobes;
    send(8'hB3);
    repeat (3) @(posedge clk);
    #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    wait_idle();
    check("hold_strobes", strobes - s0, 8);
    check("downstream_b3", ds, 8'hB3);
    win_seen = 0;
    send(8'hA5);
    send(8'h3C);
    wait_idle();
`ifdef PISO_SKID_EN
    check("b2b_span", last_en - first_en + 1, 16);
`else
    check("b2b_span", last_en - first_en + 1, 17);
`endif
    check("downstream_3c", ds, 8'h3C);
    send(8'hFF);
    in_valid = 1'b1;
    in_data  = 8'h0F;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_enable", out_enable, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    send(8'h81);
    wait_idle();
    check("downstream_81", ds, 8'h81);
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DEPTH'($urandom);
      hold     = ($urandom_range(0, 4) == 0);
      reset    = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    reset    = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1 d2_q.delete();
    send2(2'b10);
    send2(2'b01);
    repeat (8) @(posedge clk);
    #1;
    exp2 = '{2'b01, 2'b10, 2'b00, 2'b11};
    check("d2_count", d2_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("d2_strobe%0d", i), (i < d2_q.size()) ? d2_q[i] : 2'bxx, exp2[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
